// File: rtl/prim_skid_reg_slice.sv
// prim_skid_reg_slice: two-entry valid/ready skid buffer.
// valid_o, ready_o, count_o and data_o come straight from flops.
module prim_skid_reg_slice #(
  parameter int unsigned      Width      = 32,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [Width-1:0] data_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic [1:0]       count_o
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,
    StBusy  = 2'd1,
    StFull  = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic [Width-1:0] main_q, main_d;
  logic [Width-1:0] skid_q, skid_d;

  logic       valid_q, valid_d;
  logic       ready_q, ready_d;
  logic [1:0] count_q, count_d;

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = valid_i & ready_q;
  assign out_xfer = valid_q & ready_i;

  // Next state and register loads; flush wins over any handshake.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (clr_i) begin
      state_d = StEmpty;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_xfer) begin
            main_d  = data_i;
            state_d = StBusy;
          end
        end
        StBusy: begin
          unique case ({in_xfer, out_xfer})
            2'b11: main_d = data_i;
            2'b10: begin
              skid_d  = data_i;
              state_d = StFull;
            end
            2'b01: state_d = StEmpty;
            default: ;
          endcase
        end
        StFull: begin
          if (out_xfer) begin
            main_d  = skid_q;
            state_d = StBusy;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Decode the handshake outputs from the next state so they can be registered.
  always_comb begin
    valid_d = 1'b0;
    ready_d = 1'b1;
    count_d = 2'd0;
    unique case (1'b1)
      (state_d == StBusy): begin
        valid_d = 1'b1;
        count_d = 2'd1;
      end
      (state_d == StFull): begin
        valid_d = 1'b1;
        ready_d = 1'b0;
        count_d = 2'd2;
      end
      default: ;
    endcase
  end

  // Control state and registered handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StEmpty;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      count_q <= 2'd0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      count_q <= count_d;
    end
  end

  // Payload registers; they only change on a load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_q <= ResetValue;
      skid_q <= ResetValue;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign valid_o = valid_q;
  assign ready_o = ready_q;
  assign count_o = count_q;
  assign data_o  = main_q;

endmodule

// File: tb/tb_prim_skid_reg_slice.sv
// tb_prim_skid_reg_slice: random and directed checks
// of the skid slice against a queue reference model.
module tb_prim_skid_reg_slice;

  localparam logic [31:0] RV = 32'h5A5A_0F0F;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        clr_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] data_o;
  logic [1:0]  count_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] mdl[$];
  logic [31:0] src_q[$];
  logic [31:0] last_head;
  logic [31:0] prev_data;
  logic [31:0] seq;
  bit          mon_en;
  bit          prev_hold;

  prim_skid_reg_slice #(
    .Width      (32),
    .ResetValue (RV)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clr_i   (clr_i),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .count_o (count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic void chk(string name,
                              logic [31:0] act,
                              logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endfunction

  // Monitor: compare DUT against a two-deep FIFO model.
  initial begin
    forever begin
      @(negedge clk_i);
      if (mon_en) begin
        int sz;
        sz = mdl.size();
        chk("count", 32'(count_o), 32'(sz));
        chk("valid", 32'(valid_o), 32'(sz != 0));
        chk("ready", 32'(ready_o), 32'(sz < 2));
        if (sz > 0) begin
          last_head = mdl[0];
          chk("data_o", data_o, mdl[0]);
        end else begin
          chk("idle_hold", data_o, last_head);
        end
        if (prev_hold)
          chk("stall_stable", data_o, prev_data);
        prev_hold = valid_o & !ready_i & !clr_i;
        prev_data = data_o;
        if (clr_i) begin
          mdl.delete();
        end else begin
          if (ready_i && sz > 0)
            void'(mdl.pop_front());
          if (valid_i && sz < 2)
            mdl.push_back(data_i);
        end
      end
    end
  end

  // Producer holds a beat until accepted; consumer ready is random.
  task automatic pump(int cycles, int vpct, int rpct);
    bit acc;
    for (int i = 0; i < cycles; i++) begin
      if (!valid_i && src_q.size() > 0 &&
          int'($urandom_range(99)) < vpct) begin
        valid_i = 1'b1;
        data_i  = src_q.pop_front();
      end
      ready_i = (int'($urandom_range(99)) < rpct);
      @(negedge clk_i);
      acc = valid_i & ready_o;
      @(posedge clk_i);
      #1;
      if (acc) begin
        valid_i = 1'b0;
        data_i  = $urandom;
      end
    end
  endtask

  task automatic drain(int budget, int rpct);
    int n;
    n = 0;
    while ((src_q.size() > 0 || valid_i ||
            mdl.size() > 0) && n < budget) begin
      pump(1, 100, rpct);
      n++;
    end
    chk("drain_empty",
        32'(src_q.size() + mdl.size()) + 32'(valid_i),
        32'd0);
  endtask

  task automatic restart();
    mdl.delete();
    last_head = RV;
    prev_hold = 1'b0;
  endtask

  initial begin
    rst_ni  = 1'b0;
    clr_i   = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b0;
    data_i  = '0;
    mon_en  = 1'b0;
    seq     = 32'h100;
    #12;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_data", data_o, RV);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b1;
    restart();
    mon_en = 1'b1;
    @(posedge clk_i);
    #1;

    pump(5, 0, 100);

    for (int k = 1; k <= 16; k++)
      src_q.push_back(32'(k));
    pump(16, 100, 100);
    drain(20, 100);

    src_q.push_back(32'hA);
    src_q.push_back(32'hB);
    src_q.push_back(32'hC);
    pump(5, 100, 0);
    chk("bp_count", 32'(count_o), 32'd2);
    chk("bp_ready", 32'(ready_o), 32'd0);
    chk("bp_head", data_o, 32'hA);
    drain(20, 100);

    for (int i = 0; i < 10000; i++) begin
      if (src_q.size() < 4) begin
        src_q.push_back(seq);
        seq++;
      end
      pump(1, 60, 50);
    end
    drain(50, 100);

    src_q.push_back(32'h1111);
    src_q.push_back(32'h2222);
    pump(4, 100, 0);
    chk("flush_pre", 32'(count_o), 32'd2);
    clr_i   = 1'b1;
    ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    clr_i   = 1'b0;
    ready_i = 1'b0;
    chk("flush_count", 32'(count_o), 32'd0);
    chk("flush_valid", 32'(valid_o), 32'd0);
    chk("flush_ready", 32'(ready_o), 32'd1);
    chk("flush_data", data_o, 32'h1111);
    pump(3, 0, 100);

    src_q.push_back(32'h3333);
    src_q.push_back(32'h4444);
    pump(4, 100, 0);
    chk("ar_pre", 32'(count_o), 32'd2);
    #3;
    mon_en = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk("ar_valid", 32'(valid_o), 32'd0);
    chk("ar_ready", 32'(ready_o), 32'd1);
    chk("ar_count", 32'(count_o), 32'd0);
    chk("ar_data", data_o, RV);
    @(negedge clk_i);
    @(negedge clk_i);
    #2;
    rst_ni = 1'b1;
    restart();
    mon_en = 1'b1;
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 8; k++)
      src_q.push_back(32'hBEE0 + 32'(k));
    drain(40, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
